// File: rtl/gold_pkg.sv
// gold_pkg: constants and state encoding shared by the B-sequence fill controller.
package gold_pkg;
   localparam int FILL_LEN = 26;
   localparam int B20_LEN = 21;
   localparam int LEN_W = 16;
   localparam int FILL_W = $clog2(FILL_LEN + 1);
   typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
endpackage

// File: rtl/gold_seed_piso.sv
// gold_seed_piso: parallel-load, strobe-gated right-shift seed register; bit 0 is the serial output.
module gold_seed_piso #(
   parameter int W = 26
) (
   input  logic         Clock,
   input  logic         Reset_n,
   input  logic         stb,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         dout
);
   logic [W-1:0] sr;
   always_ff @(posedge Clock)
      if (!Reset_n) sr <= '0;
      else if (load) sr <= din;
      else if (stb && shift) sr <= {1'b0, sr[W-1:1]};
   assign dout = sr[0];
endmodule

// File: rtl/gold_fill_ctrl.sv
// gold_fill_ctrl: serially fills the B gold-code generator with a seed, then runs it for Run_Len chips.
// Define GOLD_FILL_REFILL_EN to reload the seed and refill at every run completion instead of idling.
module gold_fill_ctrl
   import gold_pkg::*;
(
   input  logic                Clock,
   input  logic                Reset_n,
   input  logic                Chip_Stb,
   input  logic                Start,
   input  logic                Stop,
   input  logic [FILL_LEN-1:0] Seed_B,
   input  logic [LEN_W-1:0]    Run_Len,
   output logic                Enable,
   output logic                Fill_En_B,
   output logic                New_Fill_B,
   output logic                Busy,
   output logic                Done
);
   state_t state, next;
   logic [FILL_W-1:0] fill_cnt;
   logic [LEN_W-1:0] run_cnt, run_len_q, run_inc;
   logic [FILL_LEN-1:0] load_val;
   logic accept, fill_last, run_hit, fin, load, sr0;
   assign accept = state == IDLE && Start && !Stop;
   assign fill_last = state == FILL && Chip_Stb && fill_cnt == FILL_W'(FILL_LEN - 1);
   assign run_inc = run_cnt + LEN_W'(1);
   assign run_hit = state == RUN && Chip_Stb && run_len_q != '0 && run_inc == run_len_q;
   assign fin = run_hit && !Stop;
`ifdef GOLD_FILL_REFILL_EN
   localparam state_t FIN_NEXT = FILL;
   logic [FILL_LEN-1:0] seed_q;
   always_ff @(posedge Clock)
      if (!Reset_n) seed_q <= '0;
      else if (accept) seed_q <= Seed_B;
   assign load = accept || fin;
   assign load_val = accept ? Seed_B : seed_q;
`else
   localparam state_t FIN_NEXT = IDLE;
   assign load = accept;
   assign load_val = Seed_B;
`endif
   gold_seed_piso #(.W(FILL_LEN)) u_piso (
      .Clock  (Clock),
      .Reset_n(Reset_n),
      .stb    (Chip_Stb),
      .load   (load),
      .shift  (state == FILL),
      .din    (load_val),
      .dout   (sr0)
   );
   always_ff @(posedge Clock)
      if (!Reset_n) state <= IDLE;
      else state <= next;
   // Stop outranks both a new Start and a completing run on the same cycle.
   always_comb begin
      next = Stop ? IDLE : accept ? FILL : fill_last ? RUN : fin ? FIN_NEXT : state;
   end
   always_comb begin
      Fill_En_B = state == FILL;
      Busy = state == FILL || state == RUN;
      Enable = Chip_Stb && Busy;
      New_Fill_B = Fill_En_B && sr0;
   end
   always_ff @(posedge Clock)
      if (!Reset_n) begin
         fill_cnt <= '0;
         run_cnt <= '0;
         run_len_q <= '0;
         Done <= 1'b0;
      end else begin
         Done <= fin;
         if (accept) run_len_q <= Run_Len;
         if (accept || fin) fill_cnt <= '0;
         else if (state == FILL && Chip_Stb && fill_cnt != FILL_W'(FILL_LEN)) fill_cnt <= fill_cnt + FILL_W'(1);
         if (fill_last) run_cnt <= '0;
         else if (state == RUN && Chip_Stb && run_cnt != '1) run_cnt <= run_inc;
      end
endmodule

// File: tb/tb_gold_fill_ctrl.sv
// tb_gold_fill_ctrl: directed self-checking bench for gold_fill_ctrl.
module tb_gold_fill_ctrl;
   logic Clock, Reset_n, Chip_Stb, Start, Stop;
   logic [25:0] Seed_B;
   logic [15:0] Run_Len;
   logic Enable, Fill_En_B, New_Fill_B, Busy, Done;
   int errors = 0;
   int checks = 0;

   gold_fill_ctrl dut (
      .Clock     (Clock),
      .Reset_n   (Reset_n),
      .Chip_Stb  (Chip_Stb),
      .Start     (Start),
      .Stop      (Stop),
      .Seed_B    (Seed_B),
      .Run_Len   (Run_Len),
      .Enable    (Enable),
      .Fill_En_B (Fill_En_B),
      .New_Fill_B(New_Fill_B),
      .Busy      (Busy),
      .Done      (Done)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #2;
   endtask

   task automatic outs(input string tag, input logic en, input logic fe, input logic nf, input logic bz, input logic dn);
      check({tag, ".Enable"}, 32'(Enable), 32'(en));
      check({tag, ".Fill_En_B"}, 32'(Fill_En_B), 32'(fe));
      check({tag, ".New_Fill_B"}, 32'(New_Fill_B), 32'(nf));
      check({tag, ".Busy"}, 32'(Busy), 32'(bz));
      check({tag, ".Done"}, 32'(Done), 32'(dn));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int fill_p, run_p, done_cyc, done_seen;
      logic [25:0] seed;
      Reset_n = 1'b0; Chip_Stb = 1'b1; Start = 1'b1; Stop = 1'b0;
      Seed_B = 26'h2AAAAAA; Run_Len = 16'd10;
      for (int i = 0; i < 3; i++) begin
         tick();
         outs($sformatf("reset%0d", i), 0, 0, 0, 0, 0);
      end
      Reset_n = 1'b1; Start = 1'b0;
      tick();
      outs("idle", 0, 0, 0, 0, 0);

      // basic fill + run, constant strobe
      seed = 26'h2AAAAAA;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int i = 0; i < 26; i++) begin
         outs($sformatf("fill%0d", i), 1, 1, seed[i], 1, 0);
         tick();
      end
      for (int i = 0; i < 10; i++) begin
         outs($sformatf("run%0d", i), 1, 0, 0, 1, 0);
         tick();
      end
      outs("done", 0, 0, 0, 0, 1);
      tick();
      outs("after_done", 0, 0, 0, 0, 0);

      // start during run is ignored
      seed = 26'h1234567; Seed_B = seed; Run_Len = 16'd4;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int i = 0; i < 26; i++) begin
         outs($sformatf("ign_fill%0d", i), 1, 1, seed[i], 1, 0);
         tick();
      end
      Start = 1'b1; Seed_B = 26'h3FFFFFF; Run_Len = 16'd1;
      for (int i = 0; i < 4; i++) begin
         outs($sformatf("ign_run%0d", i), 1, 0, 0, 1, 0);
         tick();
         Start = 1'b0;
      end
      outs("ign_done", 0, 0, 0, 0, 1);
      tick();

      // strobe every 4th cycle, Run_Len=3
      Seed_B = 26'h0F0F0F0; Run_Len = 16'd3;
      Chip_Stb = 1'b0; Start = 1'b1;
      tick();
      Start = 1'b0;
      fill_p = 0; run_p = 0; done_cyc = 0;
      for (int c = 1; c < 200 && done_cyc == 0; c++) begin
         Chip_Stb = (c % 4 == 3);
         #1;
         if (Enable && Fill_En_B) fill_p++;
         if (Enable && !Fill_En_B) run_p++;
         if (Done) begin
            done_cyc = c;
            check("stb_busy_at_done", 32'(Busy), 32'd0);
         end
         tick();
      end
      check("stb_fill_pulses", 32'(fill_p), 32'd26);
      check("stb_run_pulses", 32'(run_p), 32'd3);
      check("stb_done_cycle", 32'(done_cyc), 32'd116);

      // stop on the 13th fill strobe
      Chip_Stb = 1'b1; Seed_B = 26'h2AAAAAA; Run_Len = 16'd10;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      repeat (12) tick();
      outs("pre_stop", 1, 1, 0, 1, 0);
      Stop = 1'b1;
      tick();
      Stop = 1'b0;
      outs("stopped", 0, 0, 0, 0, 0);
      done_seen = 0;
      repeat (30) begin
         tick();
         if (Done || Busy) done_seen++;
      end
      check("stopped_quiet", 32'(done_seen), 32'd0);

      // Run_Len=0 runs until Stop
      Run_Len = 16'd0; Start = 1'b1;
      tick();
      Start = 1'b0;
      done_seen = 0;
      repeat (26 + 300) begin
         if (Done) done_seen++;
         tick();
      end
      check("inf_no_done", 32'(done_seen), 32'd0);
      outs("inf_running", 1, 0, 0, 1, 0);
      Stop = 1'b1;
      tick();
      Stop = 1'b0;
      outs("inf_stopped", 0, 0, 0, 0, 0);
      tick();
      outs("inf_idle", 0, 0, 0, 0, 0);

      // stop coinciding with the completing run strobe wins
      Run_Len = 16'd2; Start = 1'b1;
      tick();
      Start = 1'b0;
      repeat (27) tick();
      outs("pre_stop_fin", 1, 0, 0, 1, 0);
      Stop = 1'b1;
      tick();
      Stop = 1'b0;
      outs("stop_fin", 0, 0, 0, 0, 0);
      tick();
      outs("stop_fin2", 0, 0, 0, 0, 0);

      // Stop in IDLE suppresses Start
      Start = 1'b1; Stop = 1'b1;
      tick();
      Start = 1'b0; Stop = 1'b0;
      outs("start_stop_idle", 0, 0, 0, 0, 0);

`ifdef GOLD_FILL_REFILL_EN
      seed = 26'h2C3A5F1; Seed_B = seed; Run_Len = 16'd5;
      Start = 1'b1;
      tick();
      Start = 1'b0; Seed_B = 26'h0;
      for (int e = 0; e < 3; e++) begin
         for (int i = 0; i < 26; i++) begin
            outs($sformatf("rf_e%0d_fill%0d", e, i), 1, 1, seed[i], 1, (e > 0 && i == 0) ? 1'b1 : 1'b0);
            tick();
         end
         for (int i = 0; i < 5; i++) begin
            outs($sformatf("rf_e%0d_run%0d", e, i), 1, 0, 0, 1, 0);
            tick();
         end
      end
      Stop = 1'b1;
      tick();
      Stop = 1'b0;
      outs("rf_stopped", 0, 0, 0, 0, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
